// File: rtl/day01_pkg.sv
// Shared constants and state type for the day-01 input parser.
// ASCII codes and the parser FSM encoding live here.
package day01_pkg;

    localparam int CAL_W = 32;

    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_9  = 8'h39;
    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam logic [7:0] ASC_CR = 8'h0D;

    typedef enum logic [2:0] {
        S_RUN,
        S_FOOD,
        S_GAP,
        S_STORE,
        S_READ,
        S_DONE
    } parser_state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASC_0) && (b <= ASC_9);
    endfunction

endpackage

// File: rtl/dec_accum.sv
// Decimal digit accumulator with sticky overflow and digit-seen flag.
// acc_o is the post-update value so a digit and its newline can share a cycle.
module dec_accum #(
    parameter int W = day01_pkg::CAL_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         dv_i,
    input  logic [3:0]   dig_i,
    output logic [W-1:0] acc_o,
    output logic         ovf_o,
    output logic         ndig_o
);

    logic [W-1:0] acc_q, acc_d;
    logic         ovf_q, ovf_d;
    logic         ndig_q, ndig_d;
    logic [W+3:0] wide;

    // x*10 = x*8 + x*2, kept 4 bits wider so overflow is visible
    assign wide = ({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1)
                + {{W{1'b0}}, dig_i};

    always_comb begin
        acc_d  = acc_q;
        ovf_d  = ovf_q;
        ndig_d = ndig_q;
        if (clr_i) begin
            acc_d  = '0;
            ndig_d = 1'b0;
        end else if (dv_i) begin
            acc_d  = wide[W-1:0];
            ndig_d = 1'b1;
            ovf_d  = ovf_q | (|wide[W+3:W]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            ndig_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            ovf_q  <= ovf_d;
            ndig_q <= ndig_d;
        end
    end

    assign acc_o  = acc_d;
    assign ovf_o  = ovf_q;
    assign ndig_o = ndig_q;

endmodule

// File: rtl/day01_input_parser.sv
// ASCII puzzle-text parser driving the day-01 calorie accumulator.
// Emits food_vld per item, store_sum per group, read_max at end of input.
module day01_input_parser #(
    parameter int CAL_W     = day01_pkg::CAL_W,
    parameter int STORE_GAP = 2,
    parameter int READ_GAP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_byte,
    input  logic             in_vld,
    input  logic             in_last,
    output logic             in_rdy,
    output logic [CAL_W-1:0] food_calories,
    output logic             food_vld,
    output logic             store_sum,
    output logic             read_max,
    output logic             parse_err,
    output logic             done
);

    import day01_pkg::*;

    localparam int GW = $clog2(STORE_GAP + 1);
    localparam int RW = $clog2(READ_GAP + 1);

    parser_state_t    state_q, state_d;
    logic             rdy_q, rdy_d;
    logic             fv_q, fv_d;
    logic             st_q, st_d;
    logic             rm_q, rm_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             flush_q, flush_d;
    logic             grp_q, grp_d;
    logic [CAL_W-1:0] cal_q, cal_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [RW-1:0]    rd_q, rd_d;

    logic             take, is_dig, is_lf, is_cr;
    logic [CAL_W-1:0] acc;
    logic             ovf, ndig;

    assign take   = in_vld & rdy_q;
    assign is_dig = is_digit(in_byte);
    assign is_lf  = (in_byte == ASC_LF);
    assign is_cr  = (in_byte == ASC_CR);

    dec_accum #(.W(CAL_W)) u_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_q == S_FOOD),
        .dv_i   (take & is_dig),
        .dig_i  (in_byte[3:0]),
        .acc_o  (acc),
        .ovf_o  (ovf),
        .ndig_o (ndig)
    );

    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        flush_d = flush_q;
        err_d   = err_q | ovf;
        gap_d   = (gap_q != '0) ? gap_q - 1'b1 : gap_q;
        rd_d    = (rd_q != '0) ? rd_q - 1'b1 : rd_q;
        unique case (state_q)
            S_RUN: begin
                if (take) begin
                    flush_d = flush_q | in_last;
                    if (!is_dig && !is_lf && !is_cr) err_d = 1'b1;
                    if (is_lf || in_last) begin
                        if (ndig || is_dig)       state_d = S_FOOD;
                        else if (grp_q || in_last) state_d = S_GAP;
                    end
                end
            end
            S_FOOD: begin
                grp_d   = 1'b1;
                gap_d   = GW'(STORE_GAP - 1);
                state_d = flush_q ? S_GAP : S_RUN;
            end
            S_GAP: begin
                // store waits out the gap; end of input then waits out rd
                if (gap_q == '0) begin
                    if (grp_q)          state_d = S_STORE;
                    else if (!flush_q)  state_d = S_RUN;
                    else if (rd_q == '0) state_d = S_READ;
                end
            end
            S_STORE: begin
                grp_d   = 1'b0;
                rd_d    = RW'(READ_GAP);
                state_d = flush_q ? S_GAP : S_RUN;
            end
            S_READ:  state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_RUN;
        endcase
        rdy_d  = (state_d == S_RUN);
        fv_d   = (state_d == S_FOOD);
        cal_d  = fv_d ? acc : '0;
        st_d   = (state_d == S_STORE);
        rm_d   = (state_d == S_READ);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            rdy_q   <= 1'b0;
            fv_q    <= 1'b0;
            st_q    <= 1'b0;
            rm_q    <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            flush_q <= 1'b0;
            grp_q   <= 1'b0;
            cal_q   <= '0;
            gap_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            fv_q    <= fv_d;
            st_q    <= st_d;
            rm_q    <= rm_d;
            err_q   <= err_d;
            done_q  <= done_d;
            flush_q <= flush_d;
            grp_q   <= grp_d;
            cal_q   <= cal_d;
            gap_q   <= gap_d;
            rd_q    <= rd_d;
        end
    end

    assign in_rdy        = rdy_q;
    assign food_calories = cal_q;
    assign food_vld      = fv_q;
    assign store_sum     = st_q;
    assign read_max      = rm_q;
    assign parse_err     = err_q;
    assign done          = done_q;

endmodule

// File: tb/tb_day01_input_parser.sv
// Bench for day01_input_parser: directed and random text against an
// event-level model of the parsing rules.
module tb_day01_input_parser;

    localparam int K_FOOD  = 0;
    localparam int K_STORE = 1;
    localparam int K_READ  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_vld = 1'b0;
    logic        in_last = 1'b0;
    logic        in_rdy;
    logic [31:0] food_calories;
    logic        food_vld, store_sum, read_max, parse_err, done;

    always #5 clk = ~clk;

    day01_input_parser dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_byte       (in_byte),
        .in_vld        (in_vld),
        .in_last       (in_last),
        .in_rdy        (in_rdy),
        .food_calories (food_calories),
        .food_vld      (food_vld),
        .store_sum     (store_sum),
        .read_max      (read_max),
        .parse_err     (parse_err),
        .done          (done)
    );

    int checks = 0;
    int failures = 0;

    int          obs_k[$];
    logic [31:0] obs_v[$];
    int          exp_k[$];
    logic [31:0] exp_v[$];
    bit          exp_err;

    int cyc = 0;
    int last_food, last_store;
    int excl_viol, gap_viol, zero_viol;

    // Event recorder; clears itself while reset is held
    always @(negedge clk) begin
        if (!rst_n) begin
            obs_k.delete();
            obs_v.delete();
            excl_viol  = 0;
            gap_viol   = 0;
            zero_viol  = 0;
            last_food  = -1000;
            last_store = -1000;
        end else begin
            if (!$onehot0({food_vld, store_sum, read_max})) excl_viol++;
            if (!food_vld && food_calories != 0) zero_viol++;
            if (food_vld) begin
                obs_k.push_back(K_FOOD);
                obs_v.push_back(food_calories);
                last_food = cyc;
            end
            if (store_sum) begin
                if (cyc - last_food < 2) gap_viol++;
                obs_k.push_back(K_STORE);
                obs_v.push_back(32'h0);
                last_store = cyc;
            end
            if (read_max) begin
                if (cyc - last_store < 1) gap_viol++;
                obs_k.push_back(K_READ);
                obs_v.push_back(32'h0);
            end
        end
        cyc++;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Line-level reading of the rules: numbers end at LF, blank line
    // closes a non-empty group, end of input closes whatever is open.
    task automatic model(input string s);
        longint unsigned v;
        bit nd, grp;
        v = 0; nd = 0; grp = 0;
        exp_k.delete();
        exp_v.delete();
        exp_err = 0;
        for (int i = 0; i < s.len(); i++) begin
            byte unsigned c;
            c = s[i];
            if (c >= 8'd48 && c <= 8'd57) begin
                v = v * 10 + longint'(c - 8'd48);
                if (v > 64'hFFFF_FFFF) begin
                    exp_err = 1;
                    v = v % 64'h1_0000_0000;
                end
                nd = 1;
            end else if (c == 8'd13) begin
            end else if (c == 8'd10) begin
                if (nd) begin
                    exp_k.push_back(K_FOOD);
                    exp_v.push_back(v[31:0]);
                    v = 0; nd = 0; grp = 1;
                end else if (grp) begin
                    exp_k.push_back(K_STORE);
                    exp_v.push_back(32'h0);
                    grp = 0;
                end
            end else begin
                exp_err = 1;
            end
        end
        if (nd) begin
            exp_k.push_back(K_FOOD);
            exp_v.push_back(v[31:0]);
            grp = 1;
        end
        if (grp) begin
            exp_k.push_back(K_STORE);
            exp_v.push_back(32'h0);
        end
        exp_k.push_back(K_READ);
        exp_v.push_back(32'h0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        in_vld = 1'b0;
        in_last = 1'b0;
        repeat (2) @(negedge clk);
        chk({tag, ".rst.rdy"}, in_rdy, 0);
        chk({tag, ".rst.outs"},
            {food_calories, food_vld, store_sum, read_max, parse_err, done}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk({tag, ".post.rdy"}, in_rdy, 1);
        chk({tag, ".post.outs"},
            {food_calories, food_vld, store_sum, read_max, parse_err, done}, 0);
    endtask

    task automatic send(input string tag, input string s, input bit last,
                        input bit idle);
        for (int i = 0; i < s.len(); i++) begin
            int g;
            if (idle) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    in_vld = 1'b0;
                    in_last = 1'b0;
                end
            end
            @(negedge clk);
            in_vld = 1'b1;
            in_byte = s[i];
            in_last = last && (i == s.len() - 1);
            g = 0;
            while (!in_rdy && g < 100) begin
                @(negedge clk);
                g++;
            end
            if (g >= 100) begin
                chk({tag, ".rdy_timeout"}, in_rdy, 1);
                break;
            end
        end
        @(negedge clk);
        in_vld = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic finish_and_compare(input string tag);
        int n;
        for (int i = 0; i < 300; i++) begin
            if (done) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk({tag, ".nev"}, obs_k.size(), exp_k.size());
        n = (obs_k.size() < exp_k.size()) ? obs_k.size() : exp_k.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s.ev%0d.kind", tag, i), obs_k[i], exp_k[i]);
            chk($sformatf("%s.ev%0d.val", tag, i), obs_v[i], exp_v[i]);
        end
        chk({tag, ".err"}, parse_err, exp_err);
        chk({tag, ".done"}, done, 1);
        chk({tag, ".rdy_done"}, in_rdy, 0);
        chk({tag, ".excl"}, excl_viol, 0);
        chk({tag, ".gaps"}, gap_viol, 0);
        chk({tag, ".cal0"}, zero_viol, 0);
    endtask

    task automatic run_case(input string tag, input string s,
                            input bit idle);
        model(s);
        do_reset(tag);
        send(tag, s, 1'b1, idle);
        finish_and_compare(tag);
    endtask

    function automatic string gen();
        string s;
        int n;
        s = "";
        n = $urandom_range(1, 8);
        for (int i = 0; i < n; i++) begin
            int t;
            t = $urandom_range(0, 9);
            if (t < 6) begin
                s = {s, $sformatf("%0d", $urandom_range(0, 99999))};
                if ($urandom_range(0, 3) == 0) s = {s, "\015"};
                s = {s, "\n"};
            end else if (t < 8) begin
                s = {s, "\n"};
            end else if (t == 8) begin
                s = {s, "7x1\n"};
            end else begin
                s = {s, "98765432109\n\n"};
            end
        end
        if ($urandom_range(0, 1) == 1 && s.len() > 1)
            s = s.substr(0, s.len() - 2);
        return s;
    endfunction

    initial begin
        string smp;
        longint unsigned sum, t0, t1, t2;
        int nf, ns, nr;

        smp = {"1000\n2000\n3000\n\n4000\n\n5000\n6000\n\n",
               "7000\n8000\n9000\n\n10000"};
        run_case("sample", smp, 1'b0);
        sum = 0; t0 = 0; t1 = 0; t2 = 0; nf = 0; ns = 0; nr = 0;
        foreach (obs_k[i]) begin
            if (obs_k[i] == K_FOOD) begin
                sum += obs_v[i];
                nf++;
            end else if (obs_k[i] == K_STORE) begin
                ns++;
                if (sum > t0) begin
                    t2 = t1; t1 = t0; t0 = sum;
                end else if (sum > t1) begin
                    t2 = t1; t1 = sum;
                end else if (sum > t2) begin
                    t2 = sum;
                end
                sum = 0;
            end else begin
                nr++;
            end
        end
        chk("sample.nfood", nf, 10);
        chk("sample.nstore", ns, 5);
        chk("sample.nread", nr, 1);
        chk("sample.max", t0, 24000);
        chk("sample.top3", t0 + t1 + t2, 45000);

        run_case("blank", "5\n\n\n\n7\015\n", 1'b0);
        ns = 0;
        foreach (obs_k[i]) if (obs_k[i] == K_STORE) ns++;
        chk("blank.nstore", ns, 2);

        run_case("ovf", "4294967296\n", 1'b0);
        run_case("max", "4294967295\n", 1'b0);
        run_case("bad", "12a3\n", 1'b0);
        run_case("lead", "\n\n3\n\n\n", 1'b0);

        model("1\n");
        do_reset("rstmid");
        send("rstmid", "98", 1'b0, 1'b0);
        do_reset("rstmid2");
        send("rstmid", "1\n", 1'b1, 1'b0);
        finish_and_compare("rstmid");

        for (int k = 0; k < 20; k++) begin
            string s;
            s = gen();
            run_case($sformatf("rnd%0d", k), s, k[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/day01_input_parser.md
Name: day01_input_parser

Overview:
- Upstream driver for the day-01 calorie accumulator.
- Consumes the raw puzzle text as an ASCII byte stream and emits the accumulator's command protocol: food_calories/food_vld per item line, store_sum per elf group, and one read_max at end of input.
- Guarantees the accumulator's timing rules: store_sum never coincides with food_vld; store_sum comes at least 2 cycles after the last food_vld; read_max comes at least 1 cycle after the last store_sum.
- Sits between the byte source (file loader or UART) and the accumulator.

Parameters:
- CAL_W, 32, width of the decimal accumulator and of food_calories.
- STORE_GAP, 2, minimum cycle distance from a food_vld cycle to a later store_sum cycle.
- READ_GAP, 1, minimum cycle distance from a store_sum cycle to the read_max cycle.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-low.
- in_byte  in  8  ASCII input byte.
- in_vld  in  1  in_byte is valid.
- in_last  in  1  qualifies in_byte as the final byte of the input.
- in_rdy  out  1  parser accepts in_byte this cycle; transfer occurs when in_vld and in_rdy are both high.
- food_calories  out  CAL_W  parsed item value; held at 0 when food_vld is low.
- food_vld  out  1  one-cycle item pulse.
- store_sum  out  1  one-cycle end-of-group pulse.
- read_max  out  1  one-cycle end-of-input pulse.
- parse_err  out  1  sticky error flag.
- done  out  1  sticky; read_max has been issued.

Behaviour:
- Synchronous, active-low reset; no behaviour depends on initial blocks.
- While rst_n is low, and in the cycle after it, every output is 0 except in_rdy. in_rdy is 0 during reset and 1 from the first cycle after reset.
- Reset mid-number or mid-flush discards all state, including any pending digits and the group flag.
- All outputs are registered.
- FSM states: S_RUN, S_FOOD, S_GAP, S_STORE, S_READ, S_DONE. in_rdy = (state == S_RUN).
- S_RUN, byte '0'..'9': acc <= acc*10 + digit, evaluated modulo 2^CAL_W; set ndig.
  - If the true value exceeds 2^CAL_W - 1, set parse_err. The wrapped value is still emitted.
- S_RUN, 0x0D (CR): ignored.
- S_RUN, any other byte outside 0x0A and digits: set parse_err and drop the byte.
- S_RUN, 0x0A with ndig set: go to S_FOOD.
- S_RUN, 0x0A with ndig clear (blank line):
  - If grp_nonempty is set, go to S_GAP, then S_STORE.
  - Otherwise ignore. Consecutive blank lines and leading blank lines generate no store_sum.
- S_FOOD (1 cycle):
  - food_vld = 1 and food_calories = acc.
  - Clear acc and ndig; set grp_nonempty; load gap_cnt = STORE_GAP - 1.
  - Then return to S_RUN, or continue the flush.
- Latency:
  - A newline accepted in cycle t gives food_vld in cycle t+1.
  - A blank line accepted in cycle t gives store_sum no earlier than t+1, and never earlier than last food_vld cycle + STORE_GAP.
- S_GAP: hold while gap_cnt != 0, decrementing each cycle. gap_cnt also decrements in S_RUN.
- S_STORE (1 cycle): store_sum = 1; clear grp_nonempty; load rd_cnt = READ_GAP.
- in_last on an accepted byte: process the byte, then run the flush sequence:
  - If ndig is set, S_FOOD.
  - Then, if grp_nonempty is set, S_GAP/S_STORE.
  - Then wait out rd_cnt.
  - Then S_READ: read_max = 1 for 1 cycle.
  - Then S_DONE: done = 1, in_rdy = 0, held until reset.
  - in_last on a newline is handled identically; no duplicate pulses.
- Exclusivity: at most one of food_vld, store_sum, read_max is high in any cycle. Assert this in the bench.
- Idle in_vld cycles change nothing except the gap countdown.

Decomposition:
- Package day01_pkg:
  - CAL_W.
  - ASCII constants: ASC_0, ASC_9, ASC_LF, ASC_CR.
  - State enum parser_state_t.
- Sub-module dec_accum:
  - Inputs: clear, digit-valid, 4-bit digit.
  - Outputs: acc, sticky ovf, ndig.
  - Multiply by 10 as (acc<<3) + (acc<<1), computed at CAL_W+4 bits for overflow detection.

Test Plan:
- AoC sample "1000\n2000\n3000\n\n4000\n\n5000\n6000\n\n7000\n8000\n9000\n\n10000" with in_last on the final '0', driven into the accumulator -> 10 food_vld, 5 store_sum, 1 read_max; max_calories_sum = 24000, max_calories_top_three_sum = 45000; acc_err = 0; parse_err = 0.
- "5\n\n\n\n7\r\n" with last -> food 5, one store_sum, food 7, store_sum, read_max; exactly 2 store_sum pulses; CR ignored.
- Back-to-back bytes with in_vld always high -> every store_sum cycle is at least 2 after the preceding food_vld; read_max is at least 1 after store_sum; exclusivity assertion holds.
- "4294967296\n" with last -> food_calories = 0, parse_err = 1; "4294967295\n" -> 0xFFFFFFFF with no error.
- "12a3\n" -> parse_err = 1, food_calories = 123.
- Reset pulse after "98" -> then "1\n" with last gives food_calories = 1, store_sum, read_max, done = 1, in_rdy = 0.
